bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_PAGE, default 8'h00, meaning the address[31:24] value that selects memory.
REQ-002 The block SHALL have parameter IO_PAGE, default 8'hff, meaning the address[31:24] value that selects the display/IO slave.
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, meaning extra ACCESS cycles per transfer (range 0-15).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports m0_req and m1_req, input, 1 each, transfer request; m0 is the CPU and m1 is the DMA/debug master.
REQ-007 The block SHALL have ports mN_address, input, [31:2]; mN_data_out, input, 32; mN_data_strobes, input, 4; and mN_write, input, 1, giving the transfer attributes per master.
REQ-008 The block SHALL have ports mN_ack, output, 1, one-cycle completion pulse; mN_data_in, output, 32, read data; and mN_bus_error, output, 1, qualified by mN_ack.
REQ-009 The block SHALL have ports s_address, output, [31:2]; s_data_out, output, 32; s_data_strobes, output, 4; s_read, output, 1; s_write, output, 1; memory_cs, output, 1; display_cs, output, 1; and s_data_in, input, 32 (slave read data).

Function
REQ-010 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-011 In IDLE with no request, the FSM SHALL remain in IDLE with all slave outputs at 0.
REQ-012 In IDLE with exactly one request, the FSM SHALL grant that master.
REQ-013 In IDLE with both requests, the FSM SHALL grant the master that was not granted last (round-robin); last_grant resets to 1 so that m0 wins first.
REQ-014 On grant, the block SHALL latch the granted master's address, data_out, strobes, write and id into internal registers; later changes on master inputs SHALL NOT affect the transfer in flight.
REQ-015 On grant, the block SHALL decode latched address[31:24]: MEM_PAGE selects memory, IO_PAGE selects display, and any other value is unmapped.
REQ-016 For a mapped address, the FSM SHALL go to ACCESS; for an unmapped address, it SHALL go directly to DONE with the error flag set and SHALL assert no slave strobe.
REQ-017 In ACCESS, the block SHALL drive s_address, s_data_out and s_data_strobes from the latched values; s_write = latched write, s_read = ~latched write, and exactly one of memory_cs/display_cs = 1.
REQ-018 ACCESS SHALL last WAIT_STATES+1 cycles, counted by a 4-bit counter.
REQ-019 On the final ACCESS edge, a read SHALL capture s_data_in into the granted master's data register; the FSM then enters DONE.
REQ-020 In DONE, the block SHALL pulse ack of the granted master only, for exactly 1 cycle; mN_bus_error SHALL be 1 in that cycle only for an unmapped transfer.
REQ-021 In DONE, last_grant SHALL be updated and the FSM SHALL return to IDLE.
REQ-022 mN_data_in SHALL hold its captured value until that master's next completed read; writes and errors SHALL NOT alter it.
REQ-023 Latency from request sampled in IDLE to ack SHALL be WAIT_STATES+2 cycles for a mapped transfer and 1 cycle for an unmapped one.
REQ-024 A master SHALL hold req and its attributes until ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-025 A req that drops before grant SHALL be ignored; a req that drops after grant SHALL NOT abort the transfer.
REQ-026 All slave outputs and cs lines SHALL be 0 in IDLE and DONE.
REQ-027 The block SHALL have no back-to-back ACCESS without an intervening DONE and IDLE.

Reset
REQ-028 While reset = 0, the block SHALL asynchronously force: FSM = IDLE, last_grant = 1, wait counter = 0, all acks/bus_errors/strobes/cs = 0, s_address/s_data_out/s_data_strobes = 0, and mN_data_in = 0.
REQ-029 Reset asserted during ACCESS SHALL abort the transfer with no ack generated.
REQ-030 After reset release, the block SHALL evaluate requests from the first rising edge.

Verification
REQ-031 m0 reads 0x00000010 with memory word = 0xDEADBEEF and WAIT_STATES = 0 -> memory_cs=1 and s_read=1 for 1 cycle, then m0_ack=1 and m0_data_in=0xDEADBEEF two cycles after req.
REQ-032 m0_req and m1_req rise together and are held, reissued after each ack -> grants alternate m0, m1, m0, m1; no ack reaches the non-granted master.
REQ-033 m1 writes 0xCAFEBABE with strobes 1111 to 0xFF000004 -> display_cs=1, s_write=1, s_address=0x3FC00001, then m1_ack=1 and m1_bus_error=0.
REQ-034 m0 accesses 0x12000000 -> no cs/strobe asserted, m0_ack=1 and m0_bus_error=1 one cycle after req, and m0_data_in unchanged.
REQ-035 WAIT_STATES=3 read -> s_read held 4 cycles, ack at cycle 5; m0 address changed mid-ACCESS leaves s_address unchanged.
REQ-036 reset pulsed low mid-ACCESS -> all outputs 0 immediately with no ack; after release, a pending m1 request is granted first only if m0 is idle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with single-page address decode to a
// memory slave and a display/IO slave; unmapped pages complete with bus_error.
module bus_arbiter #(
    parameter logic [7:0]  MEM_PAGE    = 8'h00,
    parameter logic [7:0]  IO_PAGE     = 8'hff,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:2] m0_address,
    input  logic [31:0] m0_data_out,
    input  logic [3:0]  m0_data_strobes,
    input  logic        m0_write,
    output logic        m0_ack,
    output logic [31:0] m0_data_in,
    output logic        m0_bus_error,
    input  logic        m1_req,
    input  logic [31:2] m1_address,
    input  logic [31:0] m1_data_out,
    input  logic [3:0]  m1_data_strobes,
    input  logic        m1_write,
    output logic        m1_ack,
    output logic [31:0] m1_data_in,
    output logic        m1_bus_error,
    output logic [31:2] s_address,
    output logic [31:0] s_data_out,
    output logic [3:0]  s_data_strobes,
    output logic        s_read,
    output logic        s_write,
    output logic        memory_cs,
    output logic        display_cs,
    input  logic [31:0] s_data_in
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_next;

    logic        last_grant, grant_id;
    logic        any_req, pick, pick_mem, pick_io, pick_write;
    logic [31:2] pick_address, lat_address;
    logic [31:0] pick_data, lat_data, read0, read1;
    logic [3:0]  pick_strobes, lat_strobes, wait_count;
    logic        lat_write, sel_mem, sel_io, access_last;

    // Arbitration and decode of the candidate master, evaluated only in IDLE.
    always_comb begin
        any_req      = m0_req | m1_req;
        pick         = (m0_req & m1_req) ? ~last_grant : m1_req;
        pick_address = pick ? m1_address      : m0_address;
        pick_data    = pick ? m1_data_out     : m0_data_out;
        pick_strobes = pick ? m1_data_strobes : m0_data_strobes;
        pick_write   = pick ? m1_write        : m0_write;
        pick_mem     = (pick_address[31:24] == MEM_PAGE);
        pick_io      = ~pick_mem & (pick_address[31:24] == IO_PAGE);
        access_last  = (wait_count == WAIT_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        s_address      = '0;
        s_data_out     = '0;
        s_data_strobes = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        memory_cs      = 1'b0;
        display_cs     = 1'b0;
        m0_ack         = 1'b0;
        m1_ack         = 1'b0;
        m0_bus_error   = 1'b0;
        m1_bus_error   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = (pick_mem | pick_io) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                s_address      = lat_address;
                s_data_out     = lat_data;
                s_data_strobes = lat_strobes;
                s_write        = lat_write;
                s_read         = ~lat_write;
                memory_cs      = sel_mem;
                display_cs     = sel_io;
                if (access_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                m0_ack       = ~grant_id;
                m1_ack       = grant_id;
                m0_bus_error = ~grant_id & ~(sel_mem | sel_io);
                m1_bus_error = grant_id & ~(sel_mem | sel_io);
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            lat_address <= '0;
            lat_data    <= '0;
            lat_strobes <= '0;
            lat_write   <= 1'b0;
            sel_mem     <= 1'b0;
            sel_io      <= 1'b0;
            wait_count  <= '0;
            read0       <= '0;
            read1       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id    <= pick;
                        lat_address <= pick_address;
                        lat_data    <= pick_data;
                        lat_strobes <= pick_strobes;
                        lat_write   <= pick_write;
                        sel_mem     <= pick_mem;
                        sel_io      <= pick_io;
                        wait_count  <= '0;
                    end
                end
                ACCESS: begin
                    if (access_last) begin
                        wait_count <= '0;
                        if (!lat_write && !grant_id) read0 <= s_data_in;
                        if (!lat_write && grant_id)  read1 <= s_data_in;
                    end else begin
                        wait_count <= wait_count + 4'd1;
                    end
                end
                DONE: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    assign m0_data_in = read0;
    assign m1_data_in = read1;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (0 and 3 wait states) share stimulus and
// are checked every cycle against a transaction-timeline model.
module tb_bus_arbiter;

    localparam int unsigned WS_A = 0;
    localparam int unsigned WS_B = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        m_req  [2];
    logic [31:2] m_addr [2];
    logic [31:0] m_dout [2];
    logic [3:0]  m_strb [2];
    logic        m_wr   [2];
    logic [31:0] s_din;

    logic        ack0 [2], ack1 [2], berr0 [2], berr1 [2];
    logic [31:0] rd0 [2], rd1 [2];
    logic [31:2] s_addr [2];
    logic [31:0] s_dout [2];
    logic [3:0]  s_strb [2];
    logic        s_rd [2], s_wr [2], mcs [2], dcs [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        bus_arbiter #(.WAIT_STATES((d == 0) ? WS_A : WS_B)) dut (
            .clock(clock), .reset(reset),
            .m0_req(m_req[0]), .m0_address(m_addr[0]), .m0_data_out(m_dout[0]),
            .m0_data_strobes(m_strb[0]), .m0_write(m_wr[0]),
            .m0_ack(ack0[d]), .m0_data_in(rd0[d]), .m0_bus_error(berr0[d]),
            .m1_req(m_req[1]), .m1_address(m_addr[1]), .m1_data_out(m_dout[1]),
            .m1_data_strobes(m_strb[1]), .m1_write(m_wr[1]),
            .m1_ack(ack1[d]), .m1_data_in(rd1[d]), .m1_bus_error(berr1[d]),
            .s_address(s_addr[d]), .s_data_out(s_dout[d]), .s_data_strobes(s_strb[d]),
            .s_read(s_rd[d]), .s_write(s_wr[d]), .memory_cs(mcs[d]), .display_cs(dcs[d]),
            .s_data_in(s_din)
        );
    end

    // Model: each transfer is a timeline anchored at its grant edge g; k = cycles since g.
    int          cyc;
    bit          busy [2];
    int          g [2];
    bit          owner [2];
    bit          last [2];
    int          kind [2];
    logic [31:2] t_addr [2];
    logic [31:0] t_data [2];
    logic [3:0]  t_strb [2];
    bit          t_wr [2];
    logic [31:0] mrd [2][2];

    function automatic int ws_of(input int d);
        return (d == 0) ? int'(WS_A) : int'(WS_B);
    endfunction

    function automatic int page_kind(input logic [7:0] p);
        if (p == 8'h00) return 0;
        if (p == 8'hff) return 1;
        return 2;
    endfunction

    function automatic int done_k(input int d);
        return (kind[d] != 2) ? ws_of(d) + 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0;
            last[d] = 1'b1;
            mrd[d][0] = '0;
            mrd[d][1] = '0;
        end
    endfunction

    function automatic void model_edge();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int k;
            int o;
            k = cyc - g[d];
            if (busy[d]) begin
                if (k == done_k(d)) begin
                    if (kind[d] != 2 && !t_wr[d]) mrd[d][owner[d]] = s_din;
                end else if (k == done_k(d) + 1) begin
                    busy[d] = 1'b0;
                    last[d] = owner[d];
                end
            end else if (m_req[0] || m_req[1]) begin
                owner[d] = (m_req[0] && m_req[1]) ? !last[d] : m_req[1];
                o = int'(owner[d]);
                busy[d]   = 1'b1;
                g[d]      = cyc;
                t_addr[d] = m_addr[o];
                t_data[d] = m_dout[o];
                t_strb[d] = m_strb[o];
                t_wr[d]   = m_wr[o];
                kind[d]   = page_kind(m_addr[o][31:24]);
            end
        end
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else        model_edge();
        end
    end

    task automatic check(input int d, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL d%0d %s: got %0h expected %0h", d, name, got, exp);
        end
    endtask

    task automatic compare_dut(input int d);
        int k;
        bit acc, dn, e0, e1;
        k   = cyc - g[d];
        acc = busy[d] && kind[d] != 2 && k >= 0 && k <= ws_of(d);
        dn  = busy[d] && k == done_k(d);
        e0  = dn && !owner[d];
        e1  = dn && owner[d];
        check(d, "s_address",      64'(s_addr[d]), acc ? 64'(t_addr[d]) : 64'd0);
        check(d, "s_data_out",     64'(s_dout[d]), acc ? 64'(t_data[d]) : 64'd0);
        check(d, "s_data_strobes", 64'(s_strb[d]), acc ? 64'(t_strb[d]) : 64'd0);
        check(d, "s_read",         64'(s_rd[d]),   64'(acc && !t_wr[d]));
        check(d, "s_write",        64'(s_wr[d]),   64'(acc && t_wr[d]));
        check(d, "memory_cs",      64'(mcs[d]),    64'(acc && kind[d] == 0));
        check(d, "display_cs",     64'(dcs[d]),    64'(acc && kind[d] == 1));
        check(d, "m0_ack",         64'(ack0[d]),   64'(e0));
        check(d, "m1_ack",         64'(ack1[d]),   64'(e1));
        check(d, "m0_bus_error",   64'(berr0[d]),  64'(e0 && kind[d] == 2));
        check(d, "m1_bus_error",   64'(berr1[d]),  64'(e1 && kind[d] == 2));
        check(d, "m0_data_in",     64'(rd0[d]),    64'(mrd[d][0]));
        check(d, "m1_data_in",     64'(rd1[d]),    64'(mrd[d][1]));
    endtask

    initial begin
        forever begin
            @(negedge clock);
            compare_dut(0);
            compare_dut(1);
        end
    end

    task automatic set_master(input int m, input bit req, input logic [31:0] byte_addr,
                              input logic [31:0] data, input logic [3:0] strb, input bit wr);
        m_req[m]  = req;
        m_addr[m] = byte_addr[31:2];
        m_dout[m] = data;
        m_strb[m] = strb;
        m_wr[m]   = wr;
    endtask

    task automatic random_drive();
        logic [7:0]  pg;
        logic [21:0] lo;
        for (int m = 0; m < 2; m++) begin
            m_req[m] = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       pg = 8'h00;
                    1:       pg = 8'hff;
                    default: pg = 8'($urandom);
                endcase
                lo        = 22'($urandom);
                m_addr[m] = {pg, lo};
                m_dout[m] = $urandom;
                m_strb[m] = 4'($urandom);
                m_wr[m]   = 1'($urandom);
            end
        end
        s_din = $urandom;
    endtask

    initial begin
        int n;
        for (int m = 0; m < 2; m++) set_master(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        s_din = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check(d, "reset_m0_ack", 64'(ack0[d]), 64'd0);
            check(d, "reset_memory_cs", 64'(mcs[d]), 64'd0);
            check(d, "reset_m0_data_in", 64'(rd0[d]), 64'd0);
        end
        reset = 1'b1;

        // m0 memory read, then an address change while the 3-wait-state copy is mid-access.
        @(negedge clock);
        set_master(0, 1'b1, 32'h0000_0010, 32'h0, 4'hf, 1'b0);
        s_din = 32'hDEADBEEF;
        check(0, "idle_memory_cs", 64'(mcs[0]), 64'd0);
        @(negedge clock);
        check(0, "rd_memory_cs", 64'(mcs[0]), 64'd1);
        check(0, "rd_s_read", 64'(s_rd[0]), 64'd1);
        check(0, "rd_s_address", 64'(s_addr[0]), 64'h4);
        check(1, "ws_s_read_c1", 64'(s_rd[1]), 64'd1);
        @(negedge clock);
        check(0, "rd_ack", 64'(ack0[0]), 64'd1);
        check(0, "rd_data", 64'(rd0[0]), 64'hDEADBEEF);
        check(0, "rd_no_m1_ack", 64'(ack1[0]), 64'd0);
        check(0, "rd_cs_off_in_done", 64'(mcs[0]), 64'd0);
        check(0, "model_rd_pin", 64'(mrd[0][0]), 64'hDEADBEEF);
        check(1, "model_ws_busy_pin", 64'(busy[1]), 64'd1);
        m_req[0]  = 1'b0;
        m_addr[0] = 30'h3ABC_DEF;
        @(negedge clock);
        check(1, "ws_s_read_c3", 64'(s_rd[1]), 64'd1);
        check(1, "ws_addr_held", 64'(s_addr[1]), 64'h4);
        check(1, "ws_no_early_ack", 64'(ack0[1]), 64'd0);
        @(negedge clock);
        check(1, "ws_s_read_c4", 64'(s_rd[1]), 64'd1);
        @(negedge clock);
        check(1, "ws_ack", 64'(ack0[1]), 64'd1);
        check(1, "ws_data", 64'(rd0[1]), 64'hDEADBEEF);
        check(1, "ws_read_off", 64'(s_rd[1]), 64'd0);
        @(negedge clock);
        check(1, "ws_ack_one_cycle", 64'(ack0[1]), 64'd0);

        // Unmapped page: immediate error completion, no slave activity.
        set_master(0, 1'b1, 32'h1200_0000, 32'h0, 4'hf, 1'b0);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check(d, "unm_ack", 64'(ack0[d]), 64'd1);
            check(d, "unm_bus_error", 64'(berr0[d]), 64'd1);
            check(d, "unm_no_cs", 64'({mcs[d], dcs[d], s_rd[d], s_wr[d]}), 64'd0);
            check(d, "unm_data_kept", 64'(rd0[d]), 64'hDEADBEEF);
        end
        check(0, "model_unmapped_pin", 64'(kind[0]), 64'd2);
        m_req[0] = 1'b0;
        @(negedge clock);
        check(0, "unm_ack_one_cycle", 64'(ack0[0]), 64'd0);

        // m1 write to the display page.
        set_master(1, 1'b1, 32'hFF00_0004, 32'hCAFEBABE, 4'hf, 1'b1);
        @(negedge clock);
        check(0, "wr_display_cs", 64'(dcs[0]), 64'd1);
        check(0, "wr_memory_cs", 64'(mcs[0]), 64'd0);
        check(0, "wr_s_write", 64'(s_wr[0]), 64'd1);
        check(0, "wr_s_read", 64'(s_rd[0]), 64'd0);
        check(0, "wr_s_address", 64'(s_addr[0]), 64'h3FC0_0001);
        check(0, "wr_s_data_out", 64'(s_dout[0]), 64'hCAFEBABE);
        check(0, "wr_strobes", 64'(s_strb[0]), 64'hf);
        @(negedge clock);
        check(0, "wr_ack", 64'(ack1[0]), 64'd1);
        check(0, "wr_bus_error", 64'(berr1[0]), 64'd0);
        check(0, "wr_no_m0_ack", 64'(ack0[0]), 64'd0);
        check(0, "wr_m1_data_kept", 64'(rd1[0]), 64'd0);
        m_req[1] = 1'b0;
        repeat (3) @(negedge clock);
        check(1, "wr_ws_ack", 64'(ack1[1]), 64'd1);
        @(negedge clock);

        // Both masters hold requests: grants must alternate starting with m0.
        set_master(0, 1'b1, 32'h0000_0020, 32'h0, 4'hf, 1'b0);
        set_master(1, 1'b1, 32'h0000_0030, 32'h0, 4'hf, 1'b0);
        s_din = 32'h5A5A_0001;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clock);
            if (ack0[0] || ack1[0]) begin
                check(0, "rr_exclusive", 64'(ack0[0] && ack1[0]), 64'd0);
                check(0, "rr_order", 64'(ack1[0]), 64'(n % 2));
                n++;
                s_din = s_din + 32'd1;
            end
        end
        check(0, "rr_ack_count", 64'(n), 64'd4);
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (12) @(negedge clock);

        // Reset mid-access aborts both copies; a pending m1 then wins with m0 idle.
        set_master(0, 1'b1, 32'h0000_0040, 32'h0, 4'hf, 1'b0);
        s_din = 32'h0BAD_F00D;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check(d, "rst_mid_memory_cs", 64'(mcs[d]), 64'd0);
            check(d, "rst_mid_s_read", 64'(s_rd[d]), 64'd0);
            check(d, "rst_mid_s_address", 64'(s_addr[d]), 64'd0);
            check(d, "rst_mid_ack", 64'({ack0[d], ack1[d]}), 64'd0);
            check(d, "rst_mid_data_in", 64'({rd0[d], rd1[d]}), 64'd0);
        end
        m_req[0] = 1'b0;
        set_master(1, 1'b1, 32'h0000_0044, 32'h0, 4'hf, 1'b0);
        s_din = 32'h1234_5678;
        repeat (2) begin
            @(negedge clock);
            check(0, "rst_hold_no_ack", 64'({ack0[0], ack1[0]}), 64'd0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check(0, "post_rst_idle", 64'(mcs[0]), 64'd0);
        @(negedge clock);
        check(0, "post_rst_m1_cs", 64'(mcs[0]), 64'd1);
        check(0, "post_rst_m1_addr", 64'(s_addr[0]), 64'h11);
        @(negedge clock);
        check(0, "post_rst_m1_ack", 64'(ack1[0]), 64'd1);
        check(0, "post_rst_m1_data", 64'(rd1[0]), 64'h1234_5678);
        check(0, "post_rst_no_m0_ack", 64'(ack0[0]), 64'd0);
        m_req[1] = 1'b0;
        repeat (8) @(negedge clock);

        // Random traffic with occasional asynchronous reset pulses.
        repeat (3000) begin
            @(posedge clock);
            #1;
            random_drive();
            if ($urandom_range(0, 249) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock);
                    #1;
                end
                reset = 1'b1;
            end
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (10) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
